main_dec: RTL and testbench



---
 rtl/main_dec_if.sv | 46 ++++
 rtl/main_dec.sv | 85 ++++++++
 tb/tb_main_dec.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/main_dec_if.sv
// Decode/execute boundary bundle for the LEGv8 main decoder: opcode plus
// pipeline controls in, registered datapath control vector out.
interface main_dec_if;
  logic [10:0] Op;
  logic        stall;
  logic        flush;
  logic        Reg2Loc;
  logic        ALUSrc;
  logic        MemtoReg;
  logic        RegWrite;
  logic        MemRead;
  logic        MemWrite;
  logic        Branch;
  logic [1:0]  ALUOp;
  logic        NotAnInstr;

  modport master (
    output Op,
    output stall,
    output flush,
    input  Reg2Loc,
    input  ALUSrc,
    input  MemtoReg,
    input  RegWrite,
    input  MemRead,
    input  MemWrite,
    input  Branch,
    input  ALUOp,
    input  NotAnInstr
  );

  modport slave (
    input  Op,
    input  stall,
    input  flush,
    output Reg2Loc,
    output ALUSrc,
    output MemtoReg,
    output RegWrite,
    output MemRead,
    output MemWrite,
    output Branch,
    output ALUOp,
    output NotAnInstr
  );
endinterface

// File: rtl/main_dec.sv
// LEGv8 main control decoder, registered at the decode/execute boundary with stall/flush.
// Optional feature macro MAINDEC_INVALID_OP_EN: registers NotAnInstr for unrecognized opcodes.
module main_dec (
  input  logic       clk,
  input  logic       reset,
  main_dec_if.slave  bus
);

  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;

  // Vector order: Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp[1:0]
  localparam logic [8:0] CTRL_RFMT = 9'b0_0_0_1_0_0_0_10;
  localparam logic [8:0] CTRL_LDUR = 9'b0_1_1_1_1_0_0_00;
  localparam logic [8:0] CTRL_STUR = 9'b1_1_0_0_0_1_0_00;
  localparam logic [8:0] CTRL_CBZ  = 9'b1_0_0_0_0_0_1_01;
  localparam logic [8:0] CTRL_NONE = 9'b0_0_0_0_0_0_0_00;

  logic [8:0] w_ctrl;
  logic       w_known;
  logic [8:0] r_ctrl;

  always_comb begin
    w_ctrl  = CTRL_NONE;
    w_known = 1'b1;
    casez (bus.Op)
      OP_LDUR:        w_ctrl = CTRL_LDUR;
      OP_STUR:        w_ctrl = CTRL_STUR;
      11'b10110100???: w_ctrl = CTRL_CBZ;
      OP_ADD,
      OP_SUB,
      OP_AND,
      OP_ORR:         w_ctrl = CTRL_RFMT;
      default: begin
        w_ctrl  = CTRL_NONE;
        w_known = 1'b0;
      end
    endcase
  end

  // Flush outranks stall; reset discards both.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ctrl <= CTRL_NONE;
    end else if (bus.flush) begin
      r_ctrl <= CTRL_NONE;
    end else if (!bus.stall) begin
      r_ctrl <= w_ctrl;
    end
  end

`ifdef MAINDEC_INVALID_OP_EN
  logic r_not_an_instr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_not_an_instr <= 1'b0;
    end else if (bus.flush) begin
      r_not_an_instr <= 1'b0;
    end else if (!bus.stall) begin
      r_not_an_instr <= ~w_known;
    end
  end

  assign bus.NotAnInstr = r_not_an_instr;
`else
  logic w_unused_known;
  assign w_unused_known = w_known;
  assign bus.NotAnInstr = 1'b0;
`endif

  assign bus.Reg2Loc  = r_ctrl[8];
  assign bus.ALUSrc   = r_ctrl[7];
  assign bus.MemtoReg = r_ctrl[6];
  assign bus.RegWrite = r_ctrl[5];
  assign bus.MemRead  = r_ctrl[4];
  assign bus.MemWrite = r_ctrl[3];
  assign bus.Branch   = r_ctrl[2];
  assign bus.ALUOp    = r_ctrl[1:0];

endmodule

// File: tb/tb_main_dec.sv
// Self-checking bench for main_dec: scoreboard of expected control vectors per edge.
module tb_main_dec;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  logic [9:0] sb_q[$];
  logic [9:0] m_state;
  logic [9:0] exp_v;
  logic [9:0] got_v;

  main_dec_if bus ();

  main_dec dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp, NotAnInstr}
  function automatic logic [9:0] outs();
    return {bus.Reg2Loc, bus.ALUOp === 2'bxx ? 1'bx : bus.ALUSrc, bus.MemtoReg, bus.RegWrite,
            bus.MemRead, bus.MemWrite, bus.Branch, bus.ALUOp, bus.NotAnInstr};
  endfunction

  function automatic logic [9:0] model_dec(input logic [10:0] op);
    logic [10:0] cbz_pat;
    logic        inv;
`ifdef MAINDEC_INVALID_OP_EN
    inv = 1'b1;
`else
    inv = 1'b0;
`endif
    cbz_pat = 11'b10110100000;
    if (op == 11'b11111000010)                 return 10'b0_1_1_1_1_0_0_00_0;
    else if (op == 11'b11111000000)            return 10'b1_1_0_0_0_1_0_00_0;
    else if (op[10:3] == cbz_pat[10:3])        return 10'b1_0_0_0_0_0_1_01_0;
    else if (op == 11'b10001011000 || op == 11'b11001011000 ||
             op == 11'b10001010000 || op == 11'b10101010000)
                                               return 10'b0_0_0_1_0_0_0_10_0;
    else                                       return {9'b0, inv};
  endfunction

  task automatic drive(input logic [10:0] op, input logic st, input logic fl);
    @(negedge clk);
    bus.Op    = op;
    bus.stall = st;
    bus.flush = fl;
    if (fl)       m_state = 10'b0;
    else if (!st) m_state = model_dec(op);
    sb_q.push_back(m_state);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.Op = 11'b11111000010;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    m_state = 10'b0;
    repeat (2) @(posedge clk);
    #1;
    got_v = outs();
    checks++;
    if (got_v !== 10'b0) begin
      errors++;
      $display("FAIL reset_held got=%b exp=%b", got_v, 10'b0);
    end
    @(negedge clk);
    reset = 1'b1;
    drive(11'b11111000010, 1'b0, 1'b0);
    @(posedge clk); #1;
    exp_v = sb_q.pop_front();
    got_v = outs();
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL reset_release_ldur got=%b exp=%b", got_v, exp_v);
    end
    // Async reset mid-cycle with a stall pending
    @(negedge clk);
    bus.stall = 1'b1;
    #2 reset = 1'b0;
    m_state = 10'b0;
    #1;
    got_v = outs();
    checks++;
    if (got_v !== 10'b0) begin
      errors++;
      $display("FAIL reset_async got=%b exp=%b", got_v, 10'b0);
    end
    @(posedge clk); #1;
    got_v = outs();
    checks++;
    if (got_v !== 10'b0) begin
      errors++;
      $display("FAIL reset_across_edge got=%b exp=%b", got_v, 10'b0);
    end
    @(negedge clk);
    reset = 1'b1;
    drive(11'b10001011000, 1'b0, 1'b0);
    @(posedge clk); #1;
    exp_v = sb_q.pop_front();
    got_v = outs();
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL reset_stall_discarded got=%b exp=%b", got_v, exp_v);
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] ops[4] = '{11'b11111000010, 11'b11111000000, 11'b10110100000, 11'b10001011000};
    for (int i = 0; i < 4; i++) begin
      drive(ops[i], 1'b0, 1'b0);
      @(posedge clk); #1;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL b2b_queue_empty idx=%0d", i);
      end else begin
        exp_v = sb_q.pop_front();
        got_v = outs();
        checks++;
        if (got_v !== exp_v) begin
          errors++;
          $display("FAIL b2b_%0d op=%b got=%b exp=%b", i, ops[i], got_v, exp_v);
        end
      end
    end
  endtask

  task automatic test_rformat_cbz();
    logic [10:0] ops[4] = '{11'b11001011000, 11'b10001010000, 11'b10101010000, 11'b10110100111};
    for (int i = 0; i < 4; i++) begin
      drive(ops[i], 1'b0, 1'b0);
      @(posedge clk); #1;
      exp_v = sb_q.pop_front();
      got_v = outs();
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL rfmt_cbz_%0d op=%b got=%b exp=%b", i, ops[i], got_v, exp_v);
      end
    end
  endtask

  task automatic test_invalid();
    logic [10:0] ops[4] = '{11'b00000000000, 11'b11111111111, 11'b10110101000, 11'b10001011001};
    for (int i = 0; i < 4; i++) begin
      drive(ops[i], 1'b0, 1'b0);
      @(posedge clk); #1;
      exp_v = sb_q.pop_front();
      got_v = outs();
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL invalid_%0d op=%b got=%b exp=%b", i, ops[i], got_v, exp_v);
      end
    end
  endtask

  task automatic test_stall();
    drive(11'b11111000000, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      if (i >= 1 && i <= 3) drive(11'b10001011000, 1'b1, 1'b0);
      else if (i == 4)      drive(11'b10001011000, 1'b0, 1'b0);
      @(posedge clk); #1;
      exp_v = sb_q.pop_front();
      got_v = outs();
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL stall_%0d got=%b exp=%b", i, got_v, exp_v);
      end
    end
  endtask

  task automatic test_flush();
    logic [10:0] ops[4] = '{11'b11111000010, 11'b11111000010, 11'b00000000000, 11'b00000000000};
    logic        fls[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic        sts[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      drive(ops[i], sts[i], fls[i]);
      @(posedge clk); #1;
      exp_v = sb_q.pop_front();
      got_v = outs();
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL flush_%0d got=%b exp=%b", i, got_v, exp_v);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_back_to_back();
    test_rformat_cbz();
    test_invalid();
    test_stall();
    test_flush();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
